// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared ALU opcodes, forward-select codes and width defaults
package id_ex_operand_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int OP_WIDTH       = 4;
    localparam int FWD_SEL_WIDTH  = 2;

    localparam logic [OP_WIDTH-1:0] ALU_AND = 4'd0;
    localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'd1;
    localparam logic [OP_WIDTH-1:0] ALU_NOR = 4'd2;
    localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'd3;
    localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'd4;
    localparam logic [OP_WIDTH-1:0] ALU_SLL = 4'd5;
    localparam logic [OP_WIDTH-1:0] ALU_SRL = 4'd6;
    localparam logic [OP_WIDTH-1:0] ALU_LUI = 4'd7;

    localparam logic [FWD_SEL_WIDTH-1:0] FWD_REG = 2'd0;
    localparam logic [FWD_SEL_WIDTH-1:0] FWD_MEM = 2'd1;
    localparam logic [FWD_SEL_WIDTH-1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/id_ex_operand_stage_operand_forward_mux.sv
// rtl/id_ex_operand_stage_operand_forward_mux.sv - picks MEM, WB or register data for one operand
module operand_forward_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic [AW-1:0]            i_index,
    input  logic [DW-1:0]            i_reg_data,
    input  logic                     i_mem_reg_write,
    input  logic [AW-1:0]            i_mem_write_reg,
    input  logic [DW-1:0]            i_mem_alu_result,
    input  logic                     i_wb_reg_write,
    input  logic [AW-1:0]            i_wb_write_reg,
    input  logic [DW-1:0]            i_wb_write_data,
    output logic [DW-1:0]            o_data,
    output logic [FWD_SEL_WIDTH-1:0] o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 reads as zero, so a write targeting it must never be forwarded.
    assign w_mem_hit = i_mem_reg_write && (i_mem_write_reg != '0) && (i_mem_write_reg == i_index);
    assign w_wb_hit  = i_wb_reg_write  && (i_wb_write_reg  != '0) && (i_wb_write_reg  == i_index);

    always_comb begin
        o_sel  = FWD_REG;
        o_data = i_reg_data;
        if (w_mem_hit) begin
            o_sel  = FWD_MEM;
            o_data = i_mem_alu_result;
        end else if (w_wb_hit) begin
            o_sel  = FWD_WB;
            o_data = i_wb_write_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = id_ex_operand_stage_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = id_ex_operand_stage_pkg::REG_ADDR_WIDTH,
    parameter int OP_WIDTH       = id_ex_operand_stage_pkg::OP_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [OP_WIDTH-1:0]       id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [4:0]                id_shamt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_alu_src,
    input  logic                      id_reg_dst,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_mem_to_reg,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
    input  logic [DATA_WIDTH-1:0]     wb_write_data,
    output logic                      load_use_hazard,
    output logic                      ex_valid,
    output logic [OP_WIDTH-1:0]       alu_operation,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [4:0]                alu_shamt,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_mem_to_reg
);

    logic                      r_valid;
    logic [OP_WIDTH-1:0]       r_alu_op;
    logic [DATA_WIDTH-1:0]     r_rs_data;
    logic [DATA_WIDTH-1:0]     r_rt_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [4:0]                r_shamt;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [REG_ADDR_WIDTH-1:0] r_write_reg;
    logic                      r_alu_src;
    logic                      r_reg_write;
    logic                      r_mem_read;
    logic                      r_mem_write;
    logic                      r_mem_to_reg;

    logic                      w_bubble;
    logic [DATA_WIDTH-1:0]     w_rs_fwd;
    logic [DATA_WIDTH-1:0]     w_rt_fwd;
    logic [FWD_SEL_WIDTH-1:0]  w_rs_sel;
    logic [FWD_SEL_WIDTH-1:0]  w_rt_sel;
    logic [2*FWD_SEL_WIDTH-1:0] w_unused_sel;

    // The hazard is raised regardless of stall; stall simply takes priority at the edge.
    assign load_use_hazard = r_valid && r_mem_read && (r_write_reg != '0) && id_valid &&
                             ((r_write_reg == id_rs) || (r_write_reg == id_rt));

    assign w_bubble = flush || (!stall && (load_use_hazard || !id_valid));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || w_bubble) begin
            r_valid      <= 1'b0;
            r_alu_op     <= ALU_AND;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_shamt      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_write_reg  <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_alu_op     <= id_alu_op;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_shamt      <= id_shamt;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_write_reg  <= id_reg_dst ? id_rd : id_rt;
            r_alu_src    <= id_alu_src;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
        end
    end

    operand_forward_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_rs_fwd (
        .i_index          (r_rs),
        .i_reg_data       (r_rs_data),
        .i_mem_reg_write  (mem_reg_write),
        .i_mem_write_reg  (mem_write_reg),
        .i_mem_alu_result (mem_alu_result),
        .i_wb_reg_write   (wb_reg_write),
        .i_wb_write_reg   (wb_write_reg),
        .i_wb_write_data  (wb_write_data),
        .o_data           (w_rs_fwd),
        .o_sel            (w_rs_sel)
    );

    operand_forward_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_rt_fwd (
        .i_index          (r_rt),
        .i_reg_data       (r_rt_data),
        .i_mem_reg_write  (mem_reg_write),
        .i_mem_write_reg  (mem_write_reg),
        .i_mem_alu_result (mem_alu_result),
        .i_wb_reg_write   (wb_reg_write),
        .i_wb_write_reg   (wb_write_reg),
        .i_wb_write_data  (wb_write_data),
        .o_data           (w_rt_fwd),
        .o_sel            (w_rt_sel)
    );

    // Select codes are for debug visibility only; the ALU consumes the data.
    assign w_unused_sel = {w_rs_sel, w_rt_sel};

    assign ex_valid      = r_valid;
    assign alu_operation = r_alu_op;
    assign alu_shamt     = r_shamt;
    assign alu_a         = w_rs_fwd;
    assign alu_b         = r_alu_src ? r_imm : w_rt_fwd;
    assign ex_store_data = w_rt_fwd;
    assign ex_write_reg  = r_write_reg;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        mem_reg_write;
    logic [4:0]  mem_write_reg;
    logic [31:0] mem_alu_result;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        load_use_hazard, ex_valid;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt, ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int total = 0;
    int bad   = 0;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .alu_operation(alu_operation),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic src, input logic dst, input logic rw,
                          input logic mr, input logic mw, input logic m2r);
        id_valid = v; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = 5'd0;
        id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic clr_fwd();
        mem_reg_write = 0; mem_write_reg = 0; mem_alu_result = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    endtask

    initial begin
        stall = 0; flush = 0;
        clr_fwd();
        set_id(1, 4'd3, 5'd1, 5'd2, 5'd8, 32'd5, 32'd7, 32'd0, 0, 1, 1, 0, 0, 0);
        reset = 1;
        #3 reset = 0;
        tick(); tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_op", {28'd0, alu_operation}, 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_wreg", {27'd0, ex_write_reg}, 32'd0);
        chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);

        // ADD $8 <- $1 + $2
        reset = 1;
        tick();
        chk("add_op", {28'd0, alu_operation}, 32'd3);
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_wreg", {27'd0, ex_write_reg}, 32'd8);

        // SUB reading $8, producer now in MEM
        set_id(1, 4'd4, 5'd8, 5'd2, 5'd10, 32'h99, 32'd3, 32'd0, 0, 1, 1, 0, 0, 0);
        tick();
        mem_reg_write = 1; mem_write_reg = 5'd8; mem_alu_result = 32'h10;
        #1;
        chk("fwd_mem_a", alu_a, 32'h10);
        chk("fwd_mem_b", alu_b, 32'd3);
        wb_reg_write = 1; wb_write_reg = 5'd8; wb_write_data = 32'h20;
        #1;
        chk("fwd_mem_beats_wb", alu_a, 32'h10);
        mem_reg_write = 0;
        #1;
        chk("fwd_wb_a", alu_a, 32'h20);
        clr_fwd();

        // lw $9, 4($1)
        set_id(1, 4'd3, 5'd1, 5'd9, 5'd0, 32'h100, 32'd0, 32'd4, 1, 0, 1, 1, 0, 1);
        tick();
        chk("lw_memread", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_wreg", {27'd0, ex_write_reg}, 32'd9);
        chk("lw_b_imm", alu_b, 32'h104 - 32'h100);
        set_id(1, 4'd3, 5'd4, 5'd9, 5'd11, 32'd1, 32'h55, 32'd0, 0, 1, 1, 0, 0, 0);
        #1;
        chk("hazard_on", {31'd0, load_use_hazard}, 32'd1);
        tick();
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_memread", {31'd0, ex_mem_read}, 32'd0);
        chk("bubble_op", {28'd0, alu_operation}, 32'd0);
        chk("hazard_off", {31'd0, load_use_hazard}, 32'd0);
        tick();
        wb_reg_write = 1; wb_write_reg = 5'd9; wb_write_data = 32'h77;
        #1;
        chk("after_hz_valid", {31'd0, ex_valid}, 32'd1);
        chk("after_hz_b_wb", alu_b, 32'h77);
        chk("after_hz_a", alu_a, 32'd1);
        chk("after_hz_wreg", {27'd0, ex_write_reg}, 32'd11);
        clr_fwd();

        // Register 0 is never forwarded
        set_id(1, 4'd1, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0, 0, 1, 1, 0, 0, 0);
        mem_reg_write = 1; mem_write_reg = 5'd0; mem_alu_result = 32'hFFFF_FFFF;
        wb_reg_write = 1; wb_write_reg = 5'd0; wb_write_data = 32'hFFFF_FFFF;
        tick();
        chk("zero_a", alu_a, 32'd0);
        chk("zero_b", alu_b, 32'd0);
        clr_fwd();

        // Stall holds, then flush beats stall
        set_id(1, 4'd1, 5'd2, 5'd3, 5'd12, 32'hA, 32'hB, 32'd0, 0, 1, 1, 0, 0, 0);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 4'd6, 5'd20 + 5'(i), 5'd21, 5'd22, $urandom, $urandom, $urandom, 1, 0, 1, 1, 1, 1);
            tick();
            chk("stall_a", alu_a, 32'hA);
            chk("stall_b", alu_b, 32'hB);
            chk("stall_op", {28'd0, alu_operation}, 32'd1);
        end
        flush = 1;
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_a", alu_a, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        flush = 0; stall = 0;

        // id_valid=0 loads a bubble
        set_id(0, 4'd3, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 0, 1, 1, 0, 0, 0);
        tick();
        chk("novalid_valid", {31'd0, ex_valid}, 32'd0);
        chk("novalid_rw", {31'd0, ex_reg_write}, 32'd0);

        // Async reset while stalled discards the held instruction
        set_id(1, 4'd5, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 0, 1, 1, 0, 0, 0);
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1;
        #2 reset = 0;
        #1;
        chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst_op", {28'd0, alu_operation}, 32'd0);
        tick();
        reset = 1; stall = 0;

        // sw $3, 4($1) with $3 forwarded from MEM
        set_id(1, 4'd3, 5'd1, 5'd3, 5'd0, 32'h200, 32'h11, 32'd4, 1, 0, 0, 0, 1, 0);
        tick();
        mem_reg_write = 1; mem_write_reg = 5'd3; mem_alu_result = 32'hAB;
        #1;
        chk("sw_b", alu_b, 32'd4);
        chk("sw_store", ex_store_data, 32'hAB);
        chk("sw_a", alu_a, 32'h200);
        chk("sw_memwrite", {31'd0, ex_mem_write}, 32'd1);
        chk("sw_regwrite", {31'd0, ex_reg_write}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline register between decode and the 32-bit ALU.
- Captures decoded operands and control, resolves forwarding from the MEM and WB stages, and drives the ALU's operation, A, B and shamt inputs.
- Detects load-use hazards and inserts a bubble when one occurs.
- Latency is one cycle from decode to ALU inputs.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width (register 0 is hardwired zero).
- OP_WIDTH, 4, ALU operation code width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state clears on its falling edge.
- id_valid  in  1  decode slot holds a real instruction.
- id_alu_op  in  4  ALU operation (AND=0, OR=1, NOR=2, ADD=3, SUB=4, SLL=5, SRL=6, LUI=7).
- id_rs_data, id_rt_data  in  32  register-file read data.
- id_imm  in  32  sign/zero-extended immediate.
- id_shamt  in  5  shift amount.
- id_rs, id_rt, id_rd  in  5  register indices.
- id_alu_src  in  1  1 = B comes from immediate.
- id_reg_dst  in  1  1 = destination is rd, else rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits.
- stall  in  1  hold this stage.
- flush  in  1  kill this stage.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_write_reg  in  5  MEM-stage destination register.
- mem_alu_result  in  32  MEM-stage result.
- wb_reg_write  in  1  WB-stage write enable.
- wb_write_reg  in  5  WB-stage destination register.
- wb_write_data  in  32  WB-stage result.
- load_use_hazard  out  1  upstream must hold the PC and IF/ID this cycle.
- ex_valid  out  1  registered valid.
- alu_operation  out  4  to ALU.
- alu_a, alu_b  out  32  to ALU.
- alu_shamt  out  5  to ALU.
- ex_store_data  out  32  forwarded rt for stores.
- ex_write_reg  out  5  registered destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control.

Behaviour:
- Reset: every register clears to 0; ex_valid=0; all control outputs 0.
  - Asynchronous reset mid-stall or mid-hazard discards the held instruction.
- Capture priority on each rising edge, highest first:
  - flush: bubble.
  - stall: hold all registers.
  - load_use_hazard: bubble.
  - else: load the id_* fields.
- Bubble: ex_valid=0, all control bits 0, data/index fields 0, alu_operation=AND.
- On load:
  - ex_write_reg = id_reg_dst ? id_rd : id_rt.
  - Control bits are gated by id_valid; id_valid=0 loads a bubble.
- load_use_hazard (combinational): ex_valid & ex_mem_read & ex_write_reg!=0 & id_valid & (ex_write_reg==id_rs | ex_write_reg==id_rt).
  - Asserted even while stall=1; stall still wins at the edge.
- Forwarding (combinational on registered rs/rt), per operand:
  - If mem_reg_write & mem_write_reg!=0 & match: use mem_alu_result.
  - Else if wb_reg_write & wb_write_reg!=0 & match: use wb_write_data.
  - Else: use the registered data.
  - MEM beats WB when both match.
  - Index 0 is never forwarded; forwarding is evaluated even when ex_valid=0 (harmless).
- Operand outputs:
  - alu_a = forwarded rs.
  - alu_b = ex_alu_src ? ex_imm : forwarded rt.
  - ex_store_data = forwarded rt, always (independent of alu_src).
  - alu_shamt and alu_operation come straight from the registers.
- No arithmetic is done in this block; widths pass through unchanged.

Decomposition:
- Shared package holds:
  - ALU operation localparams (shared with the ALU).
  - Forward-select encoding: FWD_REG=0, FWD_MEM=1, FWD_WB=2.
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
- One sub-module: operand_forward_mux.
  - Inputs: index, registered data, MEM/WB write info.
  - Outputs: selected data and its select code.
  - Instantiated twice (rs, rt).

Test Plan:
- Assert reset low while id_valid=1 → all outputs 0; after release, first edge with id_valid=1, ADD, rs_data=5, rt_data=7 → alu_operation=3, alu_a=5, alu_b=7, ex_valid=1.
- EX holds an ADD to $8 that has advanced to MEM with result 0x10; next instruction reads rs=$8 → alu_a=0x10. Same case with WB also writing $8 with value 0x20 → MEM wins, alu_a=0x10.
- EX holds a load (lw) to $9; ID presents an instruction using rt=$9 → load_use_hazard=1; next edge ex_valid=0, ex_mem_read=0; ID instruction held and captured one cycle later, with WB forwarding supplying $9.
- MEM writes $0 with 0xFFFF_FFFF; instruction reads rs=$0, rs_data=0 → alu_a=0, no forwarding.
- stall=1 for 3 cycles with changing id_* → outputs constant. flush=1 together with stall=1 → bubble on that edge.
- SW instruction with alu_src=1, imm=4, rt=$3, MEM forwarding 0xAB for $3 → alu_b=4, ex_store_data=0xAB.
